// File: rtl/pkt_lane_dispatch.sv
// Packet-granular dispatcher: steers whole packets from one input stream onto
// one of two output lanes, alternating lanes round-robin between packets.
//
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   in_data/in_ctrl/in_wr - incoming word; nonzero ctrl marks header or last word
//   in_rdy                - word is accepted this cycle when in_wr is also high
//   laneN_data/ctrl/wr    - registered word and write strobe toward lane N
//   laneN_rdy             - lane N can absorb at least two more words
//   lane_en               - per-lane software enable, bit N for lane N
//   pkt_cnt0/pkt_cnt1     - completed packets per lane (16-bit, wrapping)
//   drop_cnt              - words offered while in_rdy was low (16-bit, wrapping)
module pkt_lane_dispatch #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] lane0_data,
    output logic [CTRL_WIDTH-1:0] lane0_ctrl,
    output logic                  lane0_wr,
    input  logic                  lane0_rdy,
    output logic [DATA_WIDTH-1:0] lane1_data,
    output logic [CTRL_WIDTH-1:0] lane1_ctrl,
    output logic                  lane1_wr,
    input  logic                  lane1_rdy,
    input  logic [1:0]            lane_en,
    output logic [15:0]           pkt_cnt0,
    output logic [15:0]           pkt_cnt1,
    output logic [15:0]           drop_cnt
);

    typedef enum logic [1:0] {StIdle, StHdr, StPayload} state_e;

    state_e      state_q;
    logic        sel_q;
    logic        rr_ptr_q;
    logic [15:0] pkt_cnt0_q;
    logic [15:0] pkt_cnt1_q;
    logic [15:0] drop_cnt_q;

    logic [1:0] lane_rdy;
    logic       other;
    logic       cand;
    logic       cand_ok;
    logic       tgt;
    logic       accept;
    logic       ctrl_nz;

    assign lane_rdy = {lane1_rdy, lane0_rdy};
    assign ctrl_nz  = |in_ctrl;

    // Lane choice for a packet start prefers rr_ptr, falls back to the other lane.
    always_comb begin
        other   = ~rr_ptr_q;
        cand    = rr_ptr_q;
        cand_ok = 1'b0;
        if (lane_en[rr_ptr_q] && lane_rdy[rr_ptr_q]) begin
            cand    = rr_ptr_q;
            cand_ok = 1'b1;
        end else if (lane_en[other] && lane_rdy[other]) begin
            cand    = other;
            cand_ok = 1'b1;
        end
    end

    // Once locked, only the locked lane's readiness matters; lane_en is ignored.
    always_comb begin
        if (state_q == StIdle) begin
            in_rdy = cand_ok;
            tgt    = cand;
        end else begin
            in_rdy = lane_rdy[sel_q];
            tgt    = sel_q;
        end
    end

    assign accept = in_wr & in_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            sel_q      <= 1'b0;
            rr_ptr_q   <= 1'b0;
            lane0_wr   <= 1'b0;
            lane1_wr   <= 1'b0;
            lane0_data <= '0;
            lane0_ctrl <= '0;
            lane1_data <= '0;
            lane1_ctrl <= '0;
            pkt_cnt0_q <= '0;
            pkt_cnt1_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            lane0_wr <= accept & ~tgt;
            lane1_wr <= accept & tgt;
            if (accept && !tgt) begin
                lane0_data <= in_data;
                lane0_ctrl <= in_ctrl;
            end
            if (accept && tgt) begin
                lane1_data <= in_data;
                lane1_ctrl <= in_ctrl;
            end
            if (in_wr && !in_rdy) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (accept) begin
                unique case (state_q)
                    StIdle: begin
                        sel_q   <= cand;
                        state_q <= ctrl_nz ? StHdr : StPayload;
                    end
                    StHdr: begin
                        if (!ctrl_nz) begin
                            state_q <= StPayload;
                        end
                    end
                    StPayload: begin
                        if (ctrl_nz) begin
                            state_q  <= StIdle;
                            rr_ptr_q <= ~sel_q;
                            if (sel_q) begin
                                pkt_cnt1_q <= pkt_cnt1_q + 16'd1;
                            end else begin
                                pkt_cnt0_q <= pkt_cnt0_q + 16'd1;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign pkt_cnt0 = pkt_cnt0_q;
    assign pkt_cnt1 = pkt_cnt1_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_pkt_lane_dispatch.sv
// Directed bench for pkt_lane_dispatch: round-robin dispatch, lane enables,
// back-pressure drops, mid-packet disable, reset mid-packet and counter wrap.
module tb_pkt_lane_dispatch;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic [63:0] lane0_data;
    logic [7:0]  lane0_ctrl;
    logic        lane0_wr;
    logic        lane0_rdy;
    logic [63:0] lane1_data;
    logic [7:0]  lane1_ctrl;
    logic        lane1_wr;
    logic        lane1_rdy;
    logic [1:0]  lane_en;
    logic [15:0] pkt_cnt0;
    logic [15:0] pkt_cnt1;
    logic [15:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pkt_lane_dispatch dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .in_wr     (in_wr),
        .in_rdy    (in_rdy),
        .lane0_data(lane0_data),
        .lane0_ctrl(lane0_ctrl),
        .lane0_wr  (lane0_wr),
        .lane0_rdy (lane0_rdy),
        .lane1_data(lane1_data),
        .lane1_ctrl(lane1_ctrl),
        .lane1_wr  (lane1_wr),
        .lane1_rdy (lane1_rdy),
        .lane_en   (lane_en),
        .pkt_cnt0  (pkt_cnt0),
        .pkt_cnt1  (pkt_cnt1),
        .drop_cnt  (drop_cnt)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // One accepted word; checks in_rdy before the edge and the lane outputs after it.
    task automatic xfer(input logic [63:0] d, input logic [7:0] c, input int lane);
        @(negedge clk);
        in_wr   = 1'b1;
        in_data = d;
        in_ctrl = c;
        #1;
        check("in_rdy", 64'(in_rdy), 64'd1);
        @(posedge clk);
        #1;
        in_wr = 1'b0;
        check("lane0_wr", 64'(lane0_wr), 64'(lane == 0));
        check("lane1_wr", 64'(lane1_wr), 64'(lane == 1));
        if (lane == 0) begin
            check("lane0_data", lane0_data, d);
            check("lane0_ctrl", 64'(lane0_ctrl), 64'(c));
        end else begin
            check("lane1_data", lane1_data, d);
            check("lane1_ctrl", 64'(lane1_ctrl), 64'(c));
        end
    endtask

    // 2 header words (0xFF), 3 data words (0x00), last word (0x80).
    task automatic send_pkt(input int lane, input logic [15:0] id);
        for (int i = 0; i < 2; i++) xfer({id, 48'(i)}, 8'hFF, lane);
        for (int i = 2; i < 5; i++) xfer({id, 48'(i)}, 8'h00, lane);
        xfer({id, 48'd5}, 8'h80, lane);
    endtask

    initial begin
        reset     = 1'b1;
        in_wr     = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        lane0_rdy = 1'b1;
        lane1_rdy = 1'b1;
        lane_en   = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_wr0", 64'(lane0_wr), 64'd0);
        check("rst_wr1", 64'(lane1_wr), 64'd0);
        check("rst_data0", lane0_data, 64'd0);
        check("rst_cnt0", 64'(pkt_cnt0), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        check("rst_in_rdy", 64'(in_rdy), 64'd1);

        // Round-robin over four packets.
        send_pkt(0, 16'hA000);
        send_pkt(1, 16'hA001);
        send_pkt(0, 16'hA002);
        send_pkt(1, 16'hA003);
        check("rr_cnt0", 64'(pkt_cnt0), 64'd2);
        check("rr_cnt1", 64'(pkt_cnt1), 64'd2);

        // No lane enabled: in_rdy low, offered word dropped.
        @(negedge clk);
        lane_en = 2'b00;
        in_wr   = 1'b1;
        in_data = 64'hDEAD;
        in_ctrl = 8'hFF;
        #1;
        check("en00_in_rdy", 64'(in_rdy), 64'd0);
        @(posedge clk);
        #1;
        in_wr = 1'b0;
        check("en00_wr0", 64'(lane0_wr), 64'd0);
        check("en00_wr1", 64'(lane1_wr), 64'd0);
        check("en00_drop", 64'(drop_cnt), 64'd1);

        // Only lane 1 enabled.
        lane_en = 2'b10;
        send_pkt(1, 16'hB000);
        send_pkt(1, 16'hB001);
        send_pkt(1, 16'hB002);
        check("en10_cnt1", 64'(pkt_cnt1), 64'd5);
        check("en10_cnt0", 64'(pkt_cnt0), 64'd2);

        // Lane 0 stalls for 3 cycles mid-payload with in_wr held high.
        lane_en = 2'b11;
        xfer(64'hC0, 8'hFF, 0);
        xfer(64'hC1, 8'h00, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            lane0_rdy = 1'b0;
            in_wr     = 1'b1;
            in_data   = 64'hBAD0 + 64'(i);
            in_ctrl   = 8'h80;
            #1;
            check("stall_in_rdy", 64'(in_rdy), 64'd0);
            @(posedge clk);
            #1;
            check("stall_wr0", 64'(lane0_wr), 64'd0);
            check("stall_wr1", 64'(lane1_wr), 64'd0);
            check("stall_data0", lane0_data, 64'hC1);
        end
        in_wr     = 1'b0;
        lane0_rdy = 1'b1;
        check("stall_drop", 64'(drop_cnt), 64'd4);
        xfer(64'hC2, 8'h00, 0);
        xfer(64'hC3, 8'h80, 0);
        check("stall_cnt0", 64'(pkt_cnt0), 64'd3);
        send_pkt(1, 16'hC100);

        // Lane 0 disabled mid-payload; packet still completes on lane 0.
        xfer(64'hD0, 8'h00, 0);
        lane_en = 2'b10;
        xfer(64'hD1, 8'h00, 0);
        xfer(64'hD2, 8'h80, 0);
        check("dis_cnt0", 64'(pkt_cnt0), 64'd4);
        send_pkt(1, 16'hD100);
        send_pkt(1, 16'hD101);
        check("dis_cnt1", 64'(pkt_cnt1), 64'd8);

        // Reset mid-payload on lane 1; next packet restarts on lane 0.
        lane_en = 2'b11;
        send_pkt(0, 16'hE000);
        xfer(64'hE1, 8'h00, 1);
        @(negedge clk);
        reset   = 1'b1;
        in_wr   = 1'b1;
        in_data = 64'hE2;
        in_ctrl = 8'h00;
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_wr = 1'b0;
        check("mrst_wr0", 64'(lane0_wr), 64'd0);
        check("mrst_wr1", 64'(lane1_wr), 64'd0);
        check("mrst_data1", lane1_data, 64'd0);
        check("mrst_cnt0", 64'(pkt_cnt0), 64'd0);
        check("mrst_cnt1", 64'(pkt_cnt1), 64'd0);
        check("mrst_drop", 64'(drop_cnt), 64'd0);
        send_pkt(0, 16'hE100);
        check("mrst_new_cnt0", 64'(pkt_cnt0), 64'd1);

        // Counter wrap on the packet counter for lane 0.
        lane_en = 2'b01;
        force dut.pkt_cnt0_q = 16'hFFFF;
        #1;
        release dut.pkt_cnt0_q;
        xfer(64'hF0, 8'h00, 0);
        xfer(64'hF1, 8'h80, 0);
        check("wrap_cnt0", 64'(pkt_cnt0), 64'd0);
        check("wrap_cnt1", 64'(pkt_cnt1), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1);
    end

endmodule
